i_decode: RTL and testbench
===========================

# i_decode

Instruction-decode stage of the 5-stage RV32I pipeline, directly downstream of instruction fetch. It consumes the fetch pipeline register (instruction, PC, PC+4) and holds the 32-entry integer register file with a write-back port. It produces the registered ID/EX bundle: operands, immediate, destination, control. One cycle of latency, with stall (hold) and flush (bubble) controls from the hazard unit.

## Interface
- DATA_WIDTH, 32, register and operand width
- INSTR_WIDTH, 32, instruction width
- PC_WIDTH, 5, program-counter width; must match the fetch stage PC width
- REG_COUNT, 32, register-file entries; register address width is $clog2(REG_COUNT) (5)

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_stall  in  1  hold the ID/EX register
- i_flush  in  1  load a bubble into the ID/EX register
- i_IF_instr  in  INSTR_WIDTH  instruction from fetch
- i_IF_program_cntr  in  PC_WIDTH  PC of i_IF_instr
- i_IF_program_cntr_next  in  PC_WIDTH  PC+4 of i_IF_instr
- i_WB_reg_wr_en  in  1  write-back enable
- i_WB_rd_addr  in  5  write-back destination
- i_WB_rd_data  in  DATA_WIDTH  write-back data
- o_ID_valid  out  1  bundle holds a real instruction
- o_ID_illegal  out  1  unsupported opcode was decoded (bundle is a bubble)
- o_ID_rs1_addr, o_ID_rs2_addr, o_ID_rd_addr  out  5 each  register indices (for forwarding)
- o_ID_rs1_data, o_ID_rs2_data  out  DATA_WIDTH  register operands
- o_ID_imm  out  DATA_WIDTH  sign-extended immediate
- o_ID_funct3  out  3  raw funct3 (branch/load/store size)
- o_ID_alu_op  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASS_B=10
- o_ID_alu_src_imm  out  1  ALU operand B = imm
- o_ID_alu_src_pc  out  1  ALU operand A = PC (AUIPC, JAL)
- o_ID_reg_wr_en, o_ID_mem_rd_en, o_ID_mem_wr_en, o_ID_branch, o_ID_jump  out  1 each  control
- o_ID_result_src  out  2  0=ALU, 1=memory, 2=PC+4
- o_ID_program_cntr, o_ID_program_cntr_next  out  PC_WIDTH  forwarded PCs

## Operation
- Opcodes decoded:
  - R 0110011: funct7[5] selects SUB/SRA.
  - I-ALU 0010011: SRAI when funct3=101 and funct7[5]=1; SUB never produced.
  - LOAD 0000011: ADD, imm, mem_rd, result_src=1.
  - STORE 0100011: ADD, imm, mem_wr, no reg write.
  - BRANCH 1100011: SUB, branch=1, no reg write.
  - JAL 1101111: jump, alu_src_pc, imm, result_src=2.
  - JALR 1100111: jump, ADD rs1+imm, result_src=2.
  - LUI 0110111: PASS_B, imm.
  - AUIPC 0010111: ADD, alu_src_pc, imm.
- Immediates, sign bit instr[31]:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R-type: 0
- reg_wr_en is forced 0 when rd=0.
- Instruction 32'h0 is a bubble with valid=0 and illegal=0; fetch emits this after reset.
- Any other undecoded opcode is a bubble with illegal=1.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - A write occurs on the rising edge when i_WB_reg_wr_en=1.
  - Write-through: a read whose address matches an active write-back (rd≠0) in the same cycle returns i_WB_rd_data.
- Pipeline register priority is flush > stall > load:
  - Flush: valid=0, illegal=0, every write/mem/branch/jump enable = 0; other fields don't-care (implementation drives 0).
  - Stall: all fields held, except rs1/rs2 data, which are re-read every stalled cycle from the held addresses (with write-through). A write-back during a stall is therefore reflected.
  - Load: all fields captured from the fetch inputs and current decode.
- Register-file writes proceed regardless of stall or flush.

## Timing
- Latency: fetch inputs at edge N appear on the outputs after edge N+1.
- Reset (asynchronous assert, synchronous release):
  - All outputs 0, including valid=0, illegal=0, all enables 0, PCs 0.
  - All 32 registers cleared to 0.
- Reset asserted mid-operation clears immediately, without waiting for a clock edge.
- Outputs are registered only; no combinational path from inputs to outputs.

## Test plan
- Reset, x1=5 and x3=7 written via WB, then fetch 0x001001B3 (add x3,x0,x1 → rd=3): next cycle valid=1, alu_op=0, rs2_data=5, reg_wr_en=1, rd=3.
- Same cycle WB writes x1=0x55 while decoding an instruction reading x1 → rs1_data=0x55 (write-through); WB to x0 → x0 still reads 0.
- Decode 0xFFF00093 (addi x1,x0,-1) → imm=0xFFFFFFFF, alu_src_imm=1. Decode 0xFE000EE3 (beq, offset −4) → imm=0xFFFFFFFC, branch=1, reg_wr_en=0.
- Stall 3 cycles holding a decode that reads x2, with WB writing x2=0x99 in stall cycle 2 → rs2_data=0x99 from the following cycle, other fields unchanged. Assert flush together with stall → valid=0, all enables 0.
- Fetch 32'h0 → valid=0, illegal=0. Fetch 0x0000007F → valid=0, illegal=1, all enables 0.
- Assert i_reset_n low between clock edges while valid=1 → outputs 0 immediately, then x1 reads 0 after release.

Source files
------------

// File: rtl/i_decode.sv
// i_decode: RV32I instruction-decode stage.
// Holds the integer register file (with write-back port and write-through
// reads) and produces the registered ID/EX bundle with stall/flush control.
module i_decode #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 5,
  parameter int REG_COUNT   = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic [INSTR_WIDTH-1:0] i_IF_instr,
  input  logic [PC_WIDTH-1:0]    i_IF_program_cntr,
  input  logic [PC_WIDTH-1:0]    i_IF_program_cntr_next,
  input  logic                   i_WB_reg_wr_en,
  input  logic [4:0]             i_WB_rd_addr,
  input  logic [DATA_WIDTH-1:0]  i_WB_rd_data,
  output logic                   o_ID_valid,
  output logic                   o_ID_illegal,
  output logic [4:0]             o_ID_rs1_addr,
  output logic [4:0]             o_ID_rs2_addr,
  output logic [4:0]             o_ID_rd_addr,
  output logic [DATA_WIDTH-1:0]  o_ID_rs1_data,
  output logic [DATA_WIDTH-1:0]  o_ID_rs2_data,
  output logic [DATA_WIDTH-1:0]  o_ID_imm,
  output logic [2:0]             o_ID_funct3,
  output logic [3:0]             o_ID_alu_op,
  output logic                   o_ID_alu_src_imm,
  output logic                   o_ID_alu_src_pc,
  output logic                   o_ID_reg_wr_en,
  output logic                   o_ID_mem_rd_en,
  output logic                   o_ID_mem_wr_en,
  output logic                   o_ID_branch,
  output logic                   o_ID_jump,
  output logic [1:0]             o_ID_result_src,
  output logic [PC_WIDTH-1:0]    o_ID_program_cntr,
  output logic [PC_WIDTH-1:0]    o_ID_program_cntr_next
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

  logic [6:0]            w_opcode;
  logic [4:0]            w_rd;
  logic [4:0]            w_rs1;
  logic [4:0]            w_rs2;
  logic [2:0]            w_funct3;
  logic                  w_funct7_5;
  logic                  w_valid;
  logic                  w_illegal;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [3:0]            w_alu_op;
  logic                  w_alu_src_imm;
  logic                  w_alu_src_pc;
  logic                  w_writes_rd;
  logic                  w_mem_rd_en;
  logic                  w_mem_wr_en;
  logic                  w_branch;
  logic                  w_jump;
  logic [1:0]            w_result_src;
  logic [4:0]            w_rd_rs1_addr;
  logic [4:0]            w_rd_rs2_addr;
  logic [DATA_WIDTH-1:0] w_rs1_data;
  logic [DATA_WIDTH-1:0] w_rs2_data;

  assign w_opcode   = i_IF_instr[6:0];
  assign w_rd       = i_IF_instr[11:7];
  assign w_funct3   = i_IF_instr[14:12];
  assign w_rs1      = i_IF_instr[19:15];
  assign w_rs2      = i_IF_instr[24:20];
  assign w_funct7_5 = i_IF_instr[30];

  // x0 reads zero; an active write-back to the same register is bypassed.
  function automatic logic [DATA_WIDTH-1:0] rf_read(input logic [4:0] addr);
    if (addr == 5'd0)
      rf_read = '0;
    else if (i_WB_reg_wr_en && (i_WB_rd_addr == addr))
      rf_read = i_WB_rd_data;
    else
      rf_read = r_regs[addr];
  endfunction

  // While stalled the operands are re-read from the held indices so a
  // write-back landing during the stall still reaches the EX stage.
  assign w_rd_rs1_addr = (i_stall && !i_flush) ? o_ID_rs1_addr : w_rs1;
  assign w_rd_rs2_addr = (i_stall && !i_flush) ? o_ID_rs2_addr : w_rs2;
  assign w_rs1_data    = rf_read(w_rd_rs1_addr);
  assign w_rs2_data    = rf_read(w_rd_rs2_addr);

  // Register file: cleared on reset, write-back is independent of stall/flush.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (i_WB_reg_wr_en && (i_WB_rd_addr != 5'd0)) begin
      r_regs[i_WB_rd_addr] <= i_WB_rd_data;
    end
  end

  // Combinational decode of the fetched instruction; unknown opcodes and
  // the all-zero post-reset word decode as bubbles with every enable low.
  always_comb begin
    w_valid       = 1'b1;
    w_illegal     = 1'b0;
    w_imm         = '0;
    w_alu_op      = ALU_ADD;
    w_alu_src_imm = 1'b0;
    w_alu_src_pc  = 1'b0;
    w_writes_rd   = 1'b0;
    w_mem_rd_en   = 1'b0;
    w_mem_wr_en   = 1'b0;
    w_branch      = 1'b0;
    w_jump        = 1'b0;
    w_result_src  = 2'd0;
    case (w_opcode)
      OP_R: begin
        w_writes_rd = 1'b1;
        case (w_funct3)
          3'b000:  w_alu_op = w_funct7_5 ? ALU_SUB : ALU_ADD;
          3'b001:  w_alu_op = ALU_SLL;
          3'b010:  w_alu_op = ALU_SLT;
          3'b011:  w_alu_op = ALU_SLTU;
          3'b100:  w_alu_op = ALU_XOR;
          3'b101:  w_alu_op = w_funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
      end
      OP_I: begin
        w_writes_rd   = 1'b1;
        w_alu_src_imm = 1'b1;
        w_imm         = {{(DATA_WIDTH-12){i_IF_instr[31]}}, i_IF_instr[31:20]};
        case (w_funct3)
          3'b000:  w_alu_op = ALU_ADD;
          3'b001:  w_alu_op = ALU_SLL;
          3'b010:  w_alu_op = ALU_SLT;
          3'b011:  w_alu_op = ALU_SLTU;
          3'b100:  w_alu_op = ALU_XOR;
          3'b101:  w_alu_op = w_funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        w_writes_rd   = 1'b1;
        w_alu_src_imm = 1'b1;
        w_mem_rd_en   = 1'b1;
        w_result_src  = 2'd1;
        w_imm         = {{(DATA_WIDTH-12){i_IF_instr[31]}}, i_IF_instr[31:20]};
      end
      OP_STORE: begin
        w_alu_src_imm = 1'b1;
        w_mem_wr_en   = 1'b1;
        w_imm         = {{(DATA_WIDTH-12){i_IF_instr[31]}}, i_IF_instr[31:25],
                         i_IF_instr[11:7]};
      end
      OP_BRANCH: begin
        w_alu_op = ALU_SUB;
        w_branch = 1'b1;
        w_imm    = {{(DATA_WIDTH-13){i_IF_instr[31]}}, i_IF_instr[31], i_IF_instr[7],
                    i_IF_instr[30:25], i_IF_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        w_writes_rd   = 1'b1;
        w_jump        = 1'b1;
        w_alu_src_pc  = 1'b1;
        w_alu_src_imm = 1'b1;
        w_result_src  = 2'd2;
        w_imm         = {{(DATA_WIDTH-21){i_IF_instr[31]}}, i_IF_instr[31],
                         i_IF_instr[19:12], i_IF_instr[20], i_IF_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        w_writes_rd   = 1'b1;
        w_jump        = 1'b1;
        w_alu_src_imm = 1'b1;
        w_result_src  = 2'd2;
        w_imm         = {{(DATA_WIDTH-12){i_IF_instr[31]}}, i_IF_instr[31:20]};
      end
      OP_LUI: begin
        w_writes_rd   = 1'b1;
        w_alu_op      = ALU_PASS_B;
        w_alu_src_imm = 1'b1;
        w_imm         = {{(DATA_WIDTH-32){i_IF_instr[31]}}, i_IF_instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        w_writes_rd   = 1'b1;
        w_alu_src_pc  = 1'b1;
        w_alu_src_imm = 1'b1;
        w_imm         = {{(DATA_WIDTH-32){i_IF_instr[31]}}, i_IF_instr[31:12], 12'b0};
      end
      default: begin
        w_valid   = 1'b0;
        w_illegal = (i_IF_instr != '0);
      end
    endcase
  end

  // ID/EX pipeline register: flush > stall > load.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n || i_flush) begin
      if (!i_reset_n) begin
        o_ID_valid <= 1'b0;
      end else begin
        o_ID_valid <= 1'b0;
      end
      o_ID_illegal           <= 1'b0;
      o_ID_rs1_addr          <= '0;
      o_ID_rs2_addr          <= '0;
      o_ID_rd_addr           <= '0;
      o_ID_rs1_data          <= '0;
      o_ID_rs2_data          <= '0;
      o_ID_imm               <= '0;
      o_ID_funct3            <= '0;
      o_ID_alu_op            <= '0;
      o_ID_alu_src_imm       <= 1'b0;
      o_ID_alu_src_pc        <= 1'b0;
      o_ID_reg_wr_en         <= 1'b0;
      o_ID_mem_rd_en         <= 1'b0;
      o_ID_mem_wr_en         <= 1'b0;
      o_ID_branch            <= 1'b0;
      o_ID_jump              <= 1'b0;
      o_ID_result_src        <= '0;
      o_ID_program_cntr      <= '0;
      o_ID_program_cntr_next <= '0;
    end else if (i_stall) begin
      o_ID_rs1_data <= w_rs1_data;
      o_ID_rs2_data <= w_rs2_data;
    end else if (!w_valid) begin
      o_ID_valid             <= 1'b0;
      o_ID_illegal           <= w_illegal;
      o_ID_rs1_addr          <= '0;
      o_ID_rs2_addr          <= '0;
      o_ID_rd_addr           <= '0;
      o_ID_rs1_data          <= '0;
      o_ID_rs2_data          <= '0;
      o_ID_imm               <= '0;
      o_ID_funct3            <= '0;
      o_ID_alu_op            <= '0;
      o_ID_alu_src_imm       <= 1'b0;
      o_ID_alu_src_pc        <= 1'b0;
      o_ID_reg_wr_en         <= 1'b0;
      o_ID_mem_rd_en         <= 1'b0;
      o_ID_mem_wr_en         <= 1'b0;
      o_ID_branch            <= 1'b0;
      o_ID_jump              <= 1'b0;
      o_ID_result_src        <= '0;
      o_ID_program_cntr      <= i_IF_program_cntr;
      o_ID_program_cntr_next <= i_IF_program_cntr_next;
    end else begin
      o_ID_valid             <= 1'b1;
      o_ID_illegal           <= 1'b0;
      o_ID_rs1_addr          <= w_rs1;
      o_ID_rs2_addr          <= w_rs2;
      o_ID_rd_addr           <= w_rd;
      o_ID_rs1_data          <= w_rs1_data;
      o_ID_rs2_data          <= w_rs2_data;
      o_ID_imm               <= w_imm;
      o_ID_funct3            <= w_funct3;
      o_ID_alu_op            <= w_alu_op;
      o_ID_alu_src_imm       <= w_alu_src_imm;
      o_ID_alu_src_pc        <= w_alu_src_pc;
      o_ID_reg_wr_en         <= w_writes_rd && (w_rd != 5'd0);
      o_ID_mem_rd_en         <= w_mem_rd_en;
      o_ID_mem_wr_en         <= w_mem_wr_en;
      o_ID_branch            <= w_branch;
      o_ID_jump              <= w_jump;
      o_ID_result_src        <= w_result_src;
      o_ID_program_cntr      <= i_IF_program_cntr;
      o_ID_program_cntr_next <= i_IF_program_cntr_next;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// tb_i_decode: directed vectors for the RV32I decode stage.
module tb_i_decode;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_IF_instr;
  logic [4:0]  i_IF_program_cntr;
  logic [4:0]  i_IF_program_cntr_next;
  logic        i_WB_reg_wr_en;
  logic [4:0]  i_WB_rd_addr;
  logic [31:0] i_WB_rd_data;
  logic        o_ID_valid, o_ID_illegal;
  logic [4:0]  o_ID_rs1_addr, o_ID_rs2_addr, o_ID_rd_addr;
  logic [31:0] o_ID_rs1_data, o_ID_rs2_data, o_ID_imm;
  logic [2:0]  o_ID_funct3;
  logic [3:0]  o_ID_alu_op;
  logic        o_ID_alu_src_imm, o_ID_alu_src_pc;
  logic        o_ID_reg_wr_en, o_ID_mem_rd_en, o_ID_mem_wr_en, o_ID_branch, o_ID_jump;
  logic [1:0]  o_ID_result_src;
  logic [4:0]  o_ID_program_cntr, o_ID_program_cntr_next;

  int errors = 0;
  int checks = 0;

  i_decode dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_IF_instr(i_IF_instr), .i_IF_program_cntr(i_IF_program_cntr),
    .i_IF_program_cntr_next(i_IF_program_cntr_next),
    .i_WB_reg_wr_en(i_WB_reg_wr_en), .i_WB_rd_addr(i_WB_rd_addr),
    .i_WB_rd_data(i_WB_rd_data),
    .o_ID_valid(o_ID_valid), .o_ID_illegal(o_ID_illegal),
    .o_ID_rs1_addr(o_ID_rs1_addr), .o_ID_rs2_addr(o_ID_rs2_addr),
    .o_ID_rd_addr(o_ID_rd_addr), .o_ID_rs1_data(o_ID_rs1_data),
    .o_ID_rs2_data(o_ID_rs2_data), .o_ID_imm(o_ID_imm), .o_ID_funct3(o_ID_funct3),
    .o_ID_alu_op(o_ID_alu_op), .o_ID_alu_src_imm(o_ID_alu_src_imm),
    .o_ID_alu_src_pc(o_ID_alu_src_pc), .o_ID_reg_wr_en(o_ID_reg_wr_en),
    .o_ID_mem_rd_en(o_ID_mem_rd_en), .o_ID_mem_wr_en(o_ID_mem_wr_en),
    .o_ID_branch(o_ID_branch), .o_ID_jump(o_ID_jump),
    .o_ID_result_src(o_ID_result_src), .o_ID_program_cntr(o_ID_program_cntr),
    .o_ID_program_cntr_next(o_ID_program_cntr_next)
  );

  // 100 MHz clock
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Control enables packed {reg_wr, mem_rd, mem_wr, branch, jump}
  function automatic logic [31:0] ens();
    return {27'd0, o_ID_reg_wr_en, o_ID_mem_rd_en, o_ID_mem_wr_en, o_ID_branch, o_ID_jump};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [4:0] pc);
    i_IF_instr             = instr;
    i_IF_program_cntr      = pc;
    i_IF_program_cntr_next = pc + 5'd4;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    i_WB_reg_wr_en = en;
    i_WB_rd_addr   = addr;
    i_WB_rd_data   = data;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_stall   = 1'b0;
    i_flush   = 1'b0;
    fetch(32'h0, 5'd0);
    wb(1'b0, 5'd0, 32'h0);
    #12;
    chk("rst_valid", {31'd0, o_ID_valid}, 32'd0);
    chk("rst_illegal", {31'd0, o_ID_illegal}, 32'd0);
    chk("rst_ens", ens(), 32'd0);
    chk("rst_pcn", {27'd0, o_ID_program_cntr_next}, 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Preload x1=5, x3=7
    wb(1'b1, 5'd1, 32'd5);
    tick();
    wb(1'b1, 5'd3, 32'd7);
    tick();
    wb(1'b0, 5'd0, 32'd0);

    // add x3,x0,x1
    fetch(32'h001001B3, 5'd4);
    tick();
    chk("add_valid", {31'd0, o_ID_valid}, 32'd1);
    chk("add_aluop", {28'd0, o_ID_alu_op}, 32'd0);
    chk("add_rs1d", o_ID_rs1_data, 32'd0);
    chk("add_rs2d", o_ID_rs2_data, 32'd5);
    chk("add_ens", ens(), 32'b10000);
    chk("add_rd", {27'd0, o_ID_rd_addr}, 32'd3);
    chk("add_imm", o_ID_imm, 32'd0);
    chk("add_pc", {27'd0, o_ID_program_cntr}, 32'd4);
    chk("add_pcn", {27'd0, o_ID_program_cntr_next}, 32'd8);

    // add x4,x1,x3 with same-cycle WB x1=0x55
    fetch(32'h00308233, 5'd8);
    wb(1'b1, 5'd1, 32'h55);
    tick();
    chk("wt_rs1d", o_ID_rs1_data, 32'h55);
    chk("wt_rs2d", o_ID_rs2_data, 32'd7);
    chk("wt_rd", {27'd0, o_ID_rd_addr}, 32'd4);

    // add x5,x0,x1 with WB to x0
    fetch(32'h001002B3, 5'd12);
    wb(1'b1, 5'd0, 32'hDEAD);
    tick();
    chk("x0wt_rs1d", o_ID_rs1_data, 32'd0);
    chk("x0wt_rs2d", o_ID_rs2_data, 32'h55);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    chk("x0_rs1d", o_ID_rs1_data, 32'd0);

    // sub x6,x3,x1
    fetch(32'h40118333, 5'd16);
    tick();
    chk("sub_aluop", {28'd0, o_ID_alu_op}, 32'd1);
    chk("sub_rs1d", o_ID_rs1_data, 32'd7);

    // addi x1,x0,-1
    fetch(32'hFFF00093, 5'd20);
    tick();
    chk("addi_imm", o_ID_imm, 32'hFFFFFFFF);
    chk("addi_srcimm", {31'd0, o_ID_alu_src_imm}, 32'd1);
    chk("addi_ens", ens(), 32'b10000);

    // srai x7,x3,4
    fetch(32'h4041D393, 5'd24);
    tick();
    chk("srai_aluop", {28'd0, o_ID_alu_op}, 32'd7);
    chk("srai_imm", o_ID_imm, 32'h404);

    // beq x0,x0,-4
    fetch(32'hFE000EE3, 5'd28);
    tick();
    chk("beq_imm", o_ID_imm, 32'hFFFFFFFC);
    chk("beq_ens", ens(), 32'b00010);
    chk("beq_aluop", {28'd0, o_ID_alu_op}, 32'd1);
    chk("beq_srcimm", {31'd0, o_ID_alu_src_imm}, 32'd0);

    // lw x8,8(x1)
    fetch(32'h0080A403, 5'd0);
    tick();
    chk("lw_ens", ens(), 32'b11000);
    chk("lw_res", {30'd0, o_ID_result_src}, 32'd1);
    chk("lw_f3", {29'd0, o_ID_funct3}, 32'd2);
    chk("lw_imm", o_ID_imm, 32'd8);
    chk("lw_rs1d", o_ID_rs1_data, 32'h55);

    // sw x3,-4(x1)
    fetch(32'hFE30AE23, 5'd4);
    tick();
    chk("sw_imm", o_ID_imm, 32'hFFFFFFFC);
    chk("sw_ens", ens(), 32'b00100);
    chk("sw_rs2d", o_ID_rs2_data, 32'd7);

    // jal x1,+8
    fetch(32'h008000EF, 5'd8);
    tick();
    chk("jal_ens", ens(), 32'b10001);
    chk("jal_srcpc", {31'd0, o_ID_alu_src_pc}, 32'd1);
    chk("jal_res", {30'd0, o_ID_result_src}, 32'd2);
    chk("jal_imm", o_ID_imm, 32'd8);

    // lui x9,0x12345
    fetch(32'h123454B7, 5'd12);
    tick();
    chk("lui_imm", o_ID_imm, 32'h12345000);
    chk("lui_aluop", {28'd0, o_ID_alu_op}, 32'd10);

    // auipc x10,1
    fetch(32'h00001517, 5'd16);
    tick();
    chk("auipc_imm", o_ID_imm, 32'h1000);
    chk("auipc_srcpc", {31'd0, o_ID_alu_src_pc}, 32'd1);
    chk("auipc_aluop", {28'd0, o_ID_alu_op}, 32'd0);

    // jalr x0,0(x1): rd=0 suppresses the write
    fetch(32'h00008067, 5'd20);
    tick();
    chk("jalr_ens", ens(), 32'b00001);
    chk("jalr_res", {30'd0, o_ID_result_src}, 32'd2);
    chk("jalr_srcpc", {31'd0, o_ID_alu_src_pc}, 32'd0);

    // add x11,x1,x2 then stall 3 cycles, WB x2=0x99 in stall cycle 2
    fetch(32'h002085B3, 5'd24);
    tick();
    chk("stl_load_rs2d", o_ID_rs2_data, 32'd0);
    i_stall = 1'b1;
    fetch(32'hFFF00093, 5'd28);
    tick();
    chk("stl1_rd", {27'd0, o_ID_rd_addr}, 32'd11);
    chk("stl1_rs2d", o_ID_rs2_data, 32'd0);
    wb(1'b1, 5'd2, 32'h99);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    chk("stl2_rs2d", o_ID_rs2_data, 32'h99);
    tick();
    chk("stl3_rs2d", o_ID_rs2_data, 32'h99);
    chk("stl3_rd", {27'd0, o_ID_rd_addr}, 32'd11);
    chk("stl3_imm", o_ID_imm, 32'd0);
    chk("stl3_pc", {27'd0, o_ID_program_cntr}, 32'd24);
    chk("stl3_ens", ens(), 32'b10000);
    i_flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, o_ID_valid}, 32'd0);
    chk("flush_ens", ens(), 32'd0);
    i_flush = 1'b0;
    i_stall = 1'b0;

    // Bubbles
    fetch(32'h0, 5'd0);
    tick();
    chk("zero_valid", {31'd0, o_ID_valid}, 32'd0);
    chk("zero_illegal", {31'd0, o_ID_illegal}, 32'd0);
    fetch(32'h0000007F, 5'd4);
    tick();
    chk("ill_valid", {31'd0, o_ID_valid}, 32'd0);
    chk("ill_illegal", {31'd0, o_ID_illegal}, 32'd1);
    chk("ill_ens", ens(), 32'd0);

    // Asynchronous reset between edges
    fetch(32'hFFF00093, 5'd8);
    tick();
    chk("prerst_valid", {31'd0, o_ID_valid}, 32'd1);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, o_ID_valid}, 32'd0);
    chk("arst_imm", o_ID_imm, 32'd0);
    chk("arst_ens", ens(), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    fetch(32'h001001B3, 5'd12);
    tick();
    chk("postrst_x1", o_ID_rs2_data, 32'd0);
    chk("postrst_valid", {31'd0, o_ID_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
